// File: rtl/bcd_lap_counter.sv
// Start/pause/direction BCD counter with lap-record slots and a multiplexed 7-segment scan.
// Define BCD_LAP_WRAP_EN to wrap at the limits instead of saturating.
module bcd_lap_digit (
  input  logic [3:0] i_d,
  input  logic       i_cin,
  input  logic       i_up,
  output logic [3:0] o_d,
  output logic       o_cout
);
  always_comb begin
    o_d    = i_d;
    o_cout = 1'b0;
    if (i_d > 4'd9) begin
      o_d = 4'd0;
    end else if (i_cin) begin
      if (i_up) begin
        if (i_d == 4'd9) begin
          o_d    = 4'd0;
          o_cout = 1'b1;
        end else begin
          o_d = i_d + 4'd1;
        end
      end else begin
        if (i_d == 4'd0) begin
          o_d    = 4'd9;
          o_cout = 1'b1;
        end else begin
          o_d = i_d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_lap_counter #(
  parameter  int N_DIGITS  = 4,
  parameter  int LAP_DEPTH = 4,
  localparam int LW        = $clog2(LAP_DEPTH),
  localparam int DW        = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  scan_tick,
  input  logic                  en_pulse,
  input  logic                  dir_pulse,
  input  logic                  record_pulse,
  input  logic [LW-1:0]         lap_sel,
  output logic [4*N_DIGITS-1:0] count,
  output logic [4*N_DIGITS-1:0] lap_value,
  output logic [LW:0]           lap_count,
  output logic                  lap_full,
  output logic [N_DIGITS-1:0]   DIGIT,
  output logic [6:0]            DISPLAY,
  output logic                  max,
  output logic                  min
);
  typedef enum logic [2:0] {INIT, COUNTUP, COUNTDOWN, PAUSEUP, PAUSEDOWN} state_t;

  state_t                              r_state, w_state_nxt;
  logic [N_DIGITS-1:0][3:0]            r_count, w_count_nxt;
  logic [N_DIGITS:0]                   w_carry;
  logic                                w_up, w_dn, w_step, w_hold, w_all9, w_zero, w_rec;
  logic [LAP_DEPTH-1:0][4*N_DIGITS-1:0] r_slot;
  logic [LW:0]                         r_lap_count;
  logic [4*N_DIGITS-1:0]               r_lap_value;
  logic [DW-1:0]                       r_idx, w_idx_nxt;
  logic [N_DIGITS-1:0]                 r_digit;
  logic [6:0]                          r_display;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b0000001;
      4'd1: seg7 = 7'b1001111;
      4'd2: seg7 = 7'b0010010;
      4'd3: seg7 = 7'b0000110;
      4'd4: seg7 = 7'b1001100;
      4'd5: seg7 = 7'b0100100;
      4'd6: seg7 = 7'b0100000;
      4'd7: seg7 = 7'b0001111;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0000100;
      default: seg7 = 7'b0000001;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= INIT;
    else       r_state <= w_state_nxt;

  // en_pulse is tested first so it wins over a simultaneous dir_pulse
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:      if (en_pulse) w_state_nxt = COUNTUP;
      COUNTUP:   if (en_pulse) w_state_nxt = PAUSEUP;   else if (dir_pulse) w_state_nxt = COUNTDOWN;
      COUNTDOWN: if (en_pulse) w_state_nxt = PAUSEDOWN; else if (dir_pulse) w_state_nxt = COUNTUP;
      PAUSEUP:   if (en_pulse) w_state_nxt = COUNTUP;   else if (dir_pulse) w_state_nxt = PAUSEDOWN;
      PAUSEDOWN: if (en_pulse) w_state_nxt = COUNTDOWN; else if (dir_pulse) w_state_nxt = PAUSEUP;
      default:   w_state_nxt = INIT;
    endcase
  end

  assign w_up     = (r_state == COUNTUP);
  assign w_dn     = (r_state == COUNTDOWN);
  assign w_step   = tick & (w_up | w_dn);
  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    bcd_lap_digit u_dig (
      .i_d    (r_count[g]),
      .i_cin  (w_carry[g]),
      .i_up   (w_up),
      .o_d    (w_count_nxt[g]),
      .o_cout (w_carry[g+1])
    );
  end

  // A carry/borrow out of the top digit means the count sits at its limit
`ifdef BCD_LAP_WRAP_EN
  assign w_hold = 1'b0 & w_carry[N_DIGITS];
`else
  assign w_hold = w_carry[N_DIGITS];
`endif

  always_comb begin
    w_all9 = 1'b1;
    w_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_count[i] != 4'd9) w_all9 = 1'b0;
      if (r_count[i] != 4'd0) w_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)                 r_count <= '0;
    else if (w_step && !w_hold) r_count <= w_count_nxt;

  assign w_rec    = record_pulse && (r_state != INIT) && !lap_full;
  assign lap_full = (r_lap_count == (LW+1)'(LAP_DEPTH));

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_slot      <= '0;
      r_lap_count <= '0;
      r_lap_value <= '0;
    end else begin
      if (w_rec) begin
        r_slot[r_lap_count[LW-1:0]] <= r_count;
        r_lap_count                 <= r_lap_count + (LW+1)'(1);
      end
      r_lap_value <= ({1'b0, lap_sel} < r_lap_count) ? r_slot[lap_sel] : '0;
    end

  // DIGIT and DISPLAY advance together so the lit digit always shows its own value
  assign w_idx_nxt = (r_idx == DW'(N_DIGITS-1)) ? '0 : r_idx + DW'(1);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_idx     <= '0;
      r_digit   <= ~N_DIGITS'(1);
      r_display <= 7'b0000001;
    end else if (scan_tick) begin
      r_idx     <= w_idx_nxt;
      r_digit   <= ~(N_DIGITS'(1) << w_idx_nxt);
      r_display <= seg7(r_count[w_idx_nxt]);
    end

  assign count     = r_count;
  assign lap_value = r_lap_value;
  assign lap_count = r_lap_count;
  assign DIGIT     = r_digit;
  assign DISPLAY   = r_display;
  assign max       = (r_state == COUNTUP || r_state == PAUSEUP) && w_all9;
  assign min       = (r_state == COUNTDOWN || r_state == PAUSEDOWN) && w_zero;
endmodule

// File: tb/tb_bcd_lap_counter.sv
// Scoreboard bench for bcd_lap_counter: stimulus queues expected values, a negedge monitor checks them.
module tb_bcd_lap_counter;
  logic        clk = 1'b0;
  logic        reset, tick, scan_tick, en_pulse, dir_pulse, record_pulse;
  logic [1:0]  lap_sel;
  logic [15:0] count, lap_value;
  logic [2:0]  lap_count;
  logic        lap_full, max, min;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;

  bcd_lap_counter #(.N_DIGITS(4), .LAP_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .scan_tick(scan_tick),
    .en_pulse(en_pulse), .dir_pulse(dir_pulse), .record_pulse(record_pulse),
    .lap_sel(lap_sel), .count(count), .lap_value(lap_value),
    .lap_count(lap_count), .lap_full(lap_full), .DIGIT(DIGIT),
    .DISPLAY(DISPLAY), .max(max), .min(min)
  );

  always #5 clk = ~clk;

  typedef enum int {S_COUNT, S_LAPV, S_LAPC, S_FULL, S_MAX, S_MIN, S_DIGIT, S_DISP} sig_e;
  typedef struct { sig_e sig; logic [31:0] exp; string name; } item_t;
  item_t sb[$];
  int n_tests = 0, n_fail = 0;

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_COUNT: actual = 32'(count);
      S_LAPV:  actual = 32'(lap_value);
      S_LAPC:  actual = 32'(lap_count);
      S_FULL:  actual = 32'(lap_full);
      S_MAX:   actual = 32'(max);
      S_MIN:   actual = 32'(min);
      S_DIGIT: actual = 32'(DIGIT);
      default: actual = 32'(DISPLAY);
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    while (sb.size() > 0) begin
      item_t it;
      logic [31:0] a;
      it = sb.pop_front();
      a  = actual(it.sig);
      n_tests++;
      if (a !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", it.name, a, it.exp);
      end
    end
  end

  task automatic chk(input sig_e s, input logic [31:0] v, input string nm);
    sb.push_back('{sig: s, exp: v, name: nm});
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL monitor_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic e, input logic d, input logic r, input logic t);
    en_pulse = e; dir_pulse = d; record_pulse = r; tick = t;
    step();
    en_pulse = 0; dir_pulse = 0; record_pulse = 0; tick = 0;
  endtask

  task automatic ticks(input int n);
    tick = 1;
    repeat (n) step();
    tick = 0;
  endtask

  task automatic scan();
    scan_tick = 1;
    step();
    scan_tick = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk(S_COUNT, 32'h0,  {tag, "_count"});
    chk(S_LAPV,  32'h0,  {tag, "_lap_value"});
    chk(S_LAPC,  32'h0,  {tag, "_lap_count"});
    chk(S_FULL,  32'h0,  {tag, "_lap_full"});
    chk(S_MAX,   32'h0,  {tag, "_max"});
    chk(S_MIN,   32'h0,  {tag, "_min"});
    chk(S_DIGIT, 32'he,  {tag, "_DIGIT"});
    chk(S_DISP,  32'h01, {tag, "_DISPLAY"});
    drain();
  endtask

  logic [15:0] lap_exp [4];

  initial begin
    lap_exp[0] = 16'h0003; lap_exp[1] = 16'h0007; lap_exp[2] = 16'h0009; lap_exp[3] = 16'h0015;
    reset = 1; tick = 0; scan_tick = 0; en_pulse = 0; dir_pulse = 0; record_pulse = 0; lap_sel = 0;
    #2;
    chk_reset("rst");
    step(); reset = 0;

    pulse(0, 0, 1, 1);
    chk(S_COUNT, 32'h0, "init_tick_ignored");
    chk(S_LAPC,  32'h0, "init_record_ignored");
    drain();

    pulse(1, 0, 0, 0);
    ticks(3); pulse(0, 0, 1, 0);
    chk(S_LAPC, 32'h1, "lap1_count"); drain();
    ticks(4); pulse(0, 0, 1, 0);
    ticks(2); pulse(0, 0, 1, 1);
    chk(S_COUNT, 32'h0010, "rec_with_tick_count");
    chk(S_LAPC,  32'h3,    "lap3_count");
    drain();

    pulse(1, 1, 0, 0);
    ticks(5);
    chk(S_COUNT, 32'h0010, "pauseup_holds");
    chk(S_MAX,   32'h0,    "pauseup_max");
    drain();

    pulse(1, 0, 0, 0);
    ticks(2);
    chk(S_COUNT, 32'h0012, "count_0012");
    chk(S_MAX,   32'h0,    "count_0012_max");
    chk(S_MIN,   32'h0,    "count_0012_min");
    drain();

    ticks(3); pulse(0, 0, 1, 0);
    chk(S_LAPC, 32'h4, "lap4_count");
    chk(S_FULL, 32'h1, "lap_full_set");
    drain();
    ticks(5); pulse(0, 0, 1, 0);
    chk(S_COUNT, 32'h0020, "count_0020");
    chk(S_LAPC,  32'h4,    "full_record_ignored");
    drain();

    for (int i = 0; i < 4; i++) begin
      lap_sel = 2'(i);
      step();
      chk(S_LAPV, 32'(lap_exp[i]), $sformatf("lap_value_%0d", i));
      drain();
    end

    scan();
    chk(S_DIGIT, 32'hd,  "scan1_DIGIT"); chk(S_DISP, 32'h12, "scan1_DISPLAY"); drain();
    scan();
    chk(S_DIGIT, 32'hb,  "scan2_DIGIT"); chk(S_DISP, 32'h01, "scan2_DISPLAY"); drain();
    scan();
    chk(S_DIGIT, 32'h7,  "scan3_DIGIT"); drain();
    scan();
    chk(S_DIGIT, 32'he,  "scan4_DIGIT"); chk(S_DISP, 32'h01, "scan4_DISPLAY"); drain();

    pulse(0, 1, 0, 0);
    ticks(1);
    chk(S_COUNT, 32'h0019, "borrow_0019"); drain();

    reset = 1; tick = 1; record_pulse = 1; scan_tick = 1;
    step();
    tick = 0; record_pulse = 0; scan_tick = 0;
    chk_reset("midrst");
    reset = 0;

    lap_sel = 0;
    pulse(1, 0, 0, 0);
    ticks(1);
    step();
    chk(S_COUNT, 32'h0001, "restart_count");
    chk(S_LAPC,  32'h0,    "restart_lap_count");
    chk(S_LAPV,  32'h0,    "restart_lap_value");
    drain();

    pulse(0, 1, 0, 0);
    ticks(1);
    chk(S_COUNT, 32'h0000, "down_to_zero");
    chk(S_MIN,   32'h1,    "min_at_zero");
    chk(S_MAX,   32'h0,    "max_at_zero");
    drain();
    ticks(1);
`ifdef BCD_LAP_WRAP_EN
    chk(S_COUNT, 32'h9999, "wrap_down");
    chk(S_MIN,   32'h0,    "wrap_down_min");
`else
    chk(S_COUNT, 32'h0000, "sat_down");
    chk(S_MIN,   32'h1,    "sat_down_min");
`endif
    drain();

    reset = 1; step(); reset = 0;
    pulse(1, 0, 0, 0);
    ticks(9998);
    chk(S_COUNT, 32'h9998, "count_9998");
    chk(S_MAX,   32'h0,    "max_9998");
    drain();
    ticks(3);
`ifdef BCD_LAP_WRAP_EN
    chk(S_COUNT, 32'h0001, "wrap_up");
    chk(S_MAX,   32'h0,    "wrap_up_max");
`else
    chk(S_COUNT, 32'h9999, "sat_up");
    chk(S_MAX,   32'h1,    "sat_up_max");
`endif
    drain();
    pulse(1, 0, 0, 0);
`ifdef BCD_LAP_WRAP_EN
    chk(S_MAX, 32'h0, "pauseup_max_wrap");
`else
    chk(S_MAX, 32'h1, "pauseup_max_sat");
`endif
    drain();
    pulse(0, 1, 0, 0);
    chk(S_MAX, 32'h0, "pausedown_max");
    chk(S_MIN, 32'h0, "pausedown_min");
    drain();
    pulse(1, 0, 0, 0);
    ticks(1);
`ifdef BCD_LAP_WRAP_EN
    chk(S_COUNT, 32'h0000, "resume_down");
`else
    chk(S_COUNT, 32'h9998, "resume_down");
`endif
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
